// File: rtl/mem_responder.sv
// Single-port memory responder: accepts one load/store request at a time,
// drives a synchronous RAM port and returns load data or a store acknowledge.
module mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a raised resp_valid stays high
  // with stable resp_rdata until it is taken.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    WR_COMMIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  // mem_addr is registered at acceptance, so the RAM sees it one edge later;
  // the countdown covers those RD_LAT RAM cycles and captures q on the next edge.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic       accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = req_write ? WR_COMMIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == 3'd0) state_nxt = RESP;
      end
      WR_COMMIT: state_nxt = RESP;
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      cnt        <= '0;
    end else if (accept) begin
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
      cnt       <= req_write ? 3'd0 : LAT_LOAD;
    end else if (state == RD_WAIT) begin
      if (cnt == 3'd0) resp_rdata <= mem_q;
      else             cnt        <= cnt - 3'd1;
    end
  end

  // Decoded straight from the state register so reset drops them asynchronously.
  assign req_ready  = (state == IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (state == RESP);
  assign mem_wren   = (state == WR_COMMIT);
  assign state_dbg  = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RD_LAT=2 main instance plus RD_LAT=1 and
// RD_LAT=4 instances sharing the same inputs for the latency sweep.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_ready;
  logic [15:0] mem_q;

  logic        req_ready, resp_valid, mem_wren, busy;
  logic [15:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0]  state_dbg;

  logic        req_ready_1, resp_valid_1, mem_wren_1, busy_1;
  logic [15:0] resp_rdata_1, mem_addr_1, mem_wdata_1;
  logic [1:0]  state_dbg_1;

  logic        req_ready_4, resp_valid_4, mem_wren_4, busy_4;
  logic [15:0] resp_rdata_4, mem_addr_4, mem_wdata_4;
  logic [1:0]  state_dbg_4;

  int n_cmp = 0;
  int n_err = 0;

  mem_responder #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy), .state_dbg(state_dbg)
  );

  mem_responder #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_1),
    .resp_valid(resp_valid_1), .resp_ready(resp_ready), .resp_rdata(resp_rdata_1),
    .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_wren(mem_wren_1),
    .mem_q(mem_q), .busy(busy_1), .state_dbg(state_dbg_1)
  );

  mem_responder #(.ADDR_W(16), .DATA_W(16), .RD_LAT(4)) u_lat4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready_4),
    .resp_valid(resp_valid_4), .resp_ready(resp_ready), .resp_rdata(resp_rdata_4),
    .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4), .mem_wren(mem_wren_4),
    .mem_q(mem_q), .busy(busy_4), .state_dbg(state_dbg_4)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_mem_wren"}, mem_wren, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; mem_q = '0;

    // Reset state, held across an edge
    #12;
    chk_reset_outputs("rst");

    // Load 0x0010 -> 0xBEEF, accepted on the first edge after release
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; mem_q = 16'hBEEF;
    reset = 1'b1;
    tick();
    chk("ld_accept_state", state_dbg, 1);
    chk("ld_mem_addr", mem_addr, 16'h0010);
    chk("ld_busy", busy, 1);
    chk("ld_req_ready", req_ready, 0);
    req_valid = 1'b0;
    tick();
    chk("ld_c1_valid", resp_valid, 0);
    tick();
    chk("ld_c2_valid", resp_valid, 0);
    tick();
    chk("ld_c3_valid", resp_valid, 1);
    chk("ld_c3_rdata", resp_rdata, 16'hBEEF);
    tick();
    chk("ld_idle_ready", req_ready, 1);
    chk("ld_idle_valid", resp_valid, 0);
    chk("ld_idle_addr_hold", mem_addr, 16'h0010);

    // Store 0x0020 <- 0x1234
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    mem_q = 16'h5555;
    tick();
    chk("st_wren", mem_wren, 1);
    chk("st_mem_addr", mem_addr, 16'h0020);
    chk("st_mem_wdata", mem_wdata, 16'h1234);
    chk("st_c1_valid", resp_valid, 0);
    req_valid = 1'b0;
    tick();
    chk("st_c2_wren", mem_wren, 0);
    chk("st_c2_valid", resp_valid, 1);
    chk("st_rdata_kept", resp_rdata, 16'hBEEF);
    tick();
    chk("st_idle_ready", req_ready, 1);
    chk("st_idle_wren", mem_wren, 0);
    chk("st_idle_wdata_hold", mem_wdata, 16'h1234);

    // Load 0x0040 with the response back-pressured
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040; mem_q = 16'hA5A5;
    resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("bp_valid", resp_valid, 1);
    chk("bp_rdata", resp_rdata, 16'hA5A5);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0050; req_wdata = 16'h1111;
    mem_q = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_rdata", resp_rdata, 16'hA5A5);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_wren", mem_wren, 0);
      chk("bp_hold_addr", mem_addr, 16'h0040);
    end
    resp_ready = 1'b1; req_valid = 1'b0;
    tick();
    chk("bp_done_state", state_dbg, 0);
    chk("bp_done_valid", resp_valid, 0);
    chk("bp_done_rdata", resp_rdata, 16'hA5A5);

    // Store 0x0030 raised while a load of 0x0060 is in flight
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0060; mem_q = 16'h7E57;
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'h9999;
    tick();
    chk("ov_c1_ready", req_ready, 0);
    chk("ov_c1_wren", mem_wren, 0);
    chk("ov_c1_addr", mem_addr, 16'h0060);
    tick();
    chk("ov_c2_wren", mem_wren, 0);
    chk("ov_c2_state", state_dbg, 1);
    tick();
    chk("ov_c3_valid", resp_valid, 1);
    chk("ov_c3_rdata", resp_rdata, 16'h7E57);
    chk("ov_c3_wren", mem_wren, 0);
    tick();
    chk("ov_idle_ready", req_ready, 1);
    chk("ov_idle_addr", mem_addr, 16'h0060);
    tick();
    chk("ov_st_wren", mem_wren, 1);
    chk("ov_st_addr", mem_addr, 16'h0030);
    chk("ov_st_wdata", mem_wdata, 16'h9999);
    req_valid = 1'b0;
    tick();
    chk("ov_st_valid", resp_valid, 1);
    chk("ov_st_rdata", resp_rdata, 16'h7E57);
    tick();
    chk("ov_end_state", state_dbg, 0);

    // Reset during WR_COMMIT
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0070; req_wdata = 16'hCAFE;
    tick();
    chk("ra_wren_before", mem_wren, 1);
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("ra_async");
    tick();
    chk_reset_outputs("ra_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ra_post_valid", resp_valid, 0);
      chk("ra_post_wren", mem_wren, 0);
      chk("ra_post_state", state_dbg, 0);
    end

    // Latency sweep: mem_q steps each cycle so captured data marks the capture edge
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010; mem_q = 16'hB000;
    tick();
    chk("sw_l1_state", state_dbg_1, 1);
    chk("sw_l4_state", state_dbg_4, 1);
    chk("sw_l4_addr", mem_addr_4, 16'h0010);
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sw_l2_valid", resp_valid, 32'(k == 3));
      chk("sw_l1_valid", resp_valid_1, 32'(k == 2));
      chk("sw_l4_valid", resp_valid_4, 32'(k == 5));
      if (k == 2) chk("sw_l1_rdata", resp_rdata_1, 16'hB001);
      if (k == 3) chk("sw_l2_rdata", resp_rdata, 16'hB002);
      if (k == 5) chk("sw_l4_rdata", resp_rdata_4, 16'hB004);
      mem_q = 16'hB000 + 16'(k);
    end
    chk("sw_l4_idle", state_dbg_4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
